// File: rtl/ysyx_23060025_muxkey_pipe.sv
// Registered, run-time-programmable key/data lookup table.
// Lookups use a valid/ready request handshake. The {data, hit, idx} result comes
// back one cycle later from a single output register that supports backpressure.
module ysyx_23060025_muxkey_pipe #(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 8,
  parameter int unsigned DATA_LEN = 32,
  // Derived from NR_KEY; not meant to be overridden.
  parameter int unsigned IDX_LEN  = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                inv_en,
  input  logic [DATA_LEN-1:0] default_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_LEN-1:0]  rsp_idx
);

  logic [NR_KEY-1:0]   valid_q;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];

  logic                lk_hit;
  logic [IDX_LEN-1:0]  lk_idx;
  logic [DATA_LEN-1:0] lk_data;
  logic                accept;

  // The single output stage can take a new request whenever it is empty or draining.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Priority lookup against the pre-edge table state. Scanning from the top down
  // lets the lowest matching index win.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_data = default_data;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == req_key)) begin
        lk_hit  = 1'b1;
        lk_idx  = IDX_LEN'(i);
        lk_data = data_q[i];
      end
    end
  end

  // Per-entry valid bits. Invalidate beats write. Out-of-range indices match no entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inv_en) begin
      valid_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_LEN'(i)) begin
          valid_q[i] <= 1'b1;
        end
      end
    end
  end

  // Key/data storage. It needs no reset because the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (rst_n && !inv_en && wr_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_LEN'(i)) begin
          key_q[i]  <= wr_key;
          data_q[i] <= wr_data;
        end
      end
    end
  end

  // Response register. It loads on accept and holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= lk_data;
      rsp_hit   <= lk_hit;
      rsp_idx   <= lk_idx;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_muxkey_pipe.sv
// Self-checking bench for ysyx_23060025_muxkey_pipe: directed vector table,
// hand-written stall/reset sequences and a random scoreboard run.
module tb_ysyx_23060025_muxkey_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [7:0]  wr_key;
  logic [31:0] wr_data;
  logic        inv_en;
  logic [31:0] default_data;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_key;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_hit;
  logic [1:0]  rsp_idx;

  ysyx_23060025_muxkey_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_key       (wr_key),
    .wr_data      (wr_data),
    .inv_en       (inv_en),
    .default_data (default_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key      (req_key),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_hit      (rsp_hit),
    .rsp_idx      (rsp_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
    logic [1:0]  idx;
  } rsp_t;

  typedef struct packed {
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [7:0]  wr_key;
    logic [31:0] wr_data;
    logic        inv_en;
    logic        req_valid;
    logic [7:0]  req_key;
    logic [31:0] dflt;
    logic        e_hit;
    logic [1:0]  e_idx;
    logic [31:0] e_data;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference table model
  logic        m_valid [4];
  logic [7:0]  m_key   [4];
  logic [31:0] m_data  [4];
  rsp_t        sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic rsp_t model_lookup(input logic [7:0] k, input logic [31:0] d);
    rsp_t r;
    r.data = d;
    r.hit  = 1'b0;
    r.idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m_valid[i] && m_key[i] == k) begin
        r.data = m_data[i];
        r.hit  = 1'b1;
        r.idx  = 2'(i);
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  // One clock with the inputs already driven. It checks the handshake and the
  // held response, then updates the scoreboard and table model for this edge.
  task automatic cycle(input logic use_exp, input rsp_t exp_r);
    logic exp_ready;
    rsp_t r;
    #1;
    exp_ready = (sb.size() == 0) || rsp_ready;
    chk("req_ready", req_ready, exp_ready);
    if (sb.size() > 0) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, sb[0].data);
      chk("rsp_hit", rsp_hit, sb[0].hit);
      chk("rsp_idx", rsp_idx, sb[0].idx);
      if (rsp_ready) void'(sb.pop_front());
    end else begin
      chk("rsp_valid_idle", rsp_valid, 0);
    end
    if (req_valid && exp_ready) begin
      r = use_exp ? exp_r : model_lookup(req_key, default_data);
      sb.push_back(r);
    end
    if (inv_en) model_clear();
    else if (wr_en) begin
      m_valid[wr_idx] = 1'b1;
      m_key[wr_idx]   = wr_key;
      m_data[wr_idx]  = wr_data;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_idx = 0; wr_key = 0; wr_data = 0; inv_en = 0;
    req_valid = 0; req_key = 0; default_data = 0; rsp_ready = 1;
  endtask

  vec_t tbl[15];
  rsp_t none;
  logic [7:0] keys[4];
  int accepted;

  initial begin
    none = '0;
    keys[0] = 8'h12; keys[1] = 8'h34; keys[2] = 8'h56; keys[3] = 8'h78;
    model_clear();
    // wr_en idx key data inv req_v req_key dflt | e_hit e_idx e_data
    tbl[0]  = '{1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h00, 32'hDEADBEEF, 1'b0, 2'd0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 2'd1, 8'h12, 32'h11112222, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 2'd0, 32'h0};
    tbl[2]  = '{1'b1, 2'd3, 8'h34, 32'hAAAA5555, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 2'd0, 32'h0};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h34, 32'h0, 1'b1, 2'd3, 32'hAAAA5555};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h12, 32'h0, 1'b1, 2'd1, 32'h11112222};
    tbl[5]  = '{1'b1, 2'd0, 8'h7F, 32'hA0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 2'd0, 32'h0};
    tbl[6]  = '{1'b1, 2'd2, 8'h7F, 32'hA2, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 2'd0, 32'h0};
    tbl[7]  = '{1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h7F, 32'h1, 1'b1, 2'd0, 32'hA0};
    tbl[8]  = '{1'b1, 2'd0, 8'h00, 32'hB0, 1'b0, 1'b1, 8'h7F, 32'h1, 1'b1, 2'd0, 32'hA0};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h7F, 32'h1, 1'b1, 2'd2, 32'hA2};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h00, 32'h5, 1'b1, 2'd0, 32'hB0};
    tbl[11] = '{1'b1, 2'd2, 8'h55, 32'h55, 1'b1, 1'b1, 8'h12, 32'h0, 1'b1, 2'd1, 32'h11112222};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h55, 32'hCAFEF00D, 1'b0, 2'd0, 32'hCAFEF00D};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h34, 32'h1, 1'b0, 2'd0, 32'h1};
    tbl[14] = '{1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h00, 32'h2, 1'b0, 2'd0, 32'h2};

    // Reset
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_hit", rsp_hit, 0);
    chk("reset_rsp_idx", rsp_idx, 0);
    rst_n = 1;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      wr_en = tbl[i].wr_en; wr_idx = tbl[i].wr_idx; wr_key = tbl[i].wr_key;
      wr_data = tbl[i].wr_data; inv_en = tbl[i].inv_en; req_valid = tbl[i].req_valid;
      req_key = tbl[i].req_key; default_data = tbl[i].dflt; rsp_ready = 1;
      cycle(1'b1, '{tbl[i].e_data, tbl[i].e_hit, tbl[i].e_idx});
    end
    idle_inputs();
    cycle(1'b0, none);

    // Backpressure: accept, stall three cycles (with a table write), then release
    wr_en = 1; wr_idx = 1; wr_key = 8'h12; wr_data = 32'h11112222;
    cycle(1'b0, none);
    idle_inputs();
    req_valid = 1; req_key = 8'h12; rsp_ready = 0; default_data = 32'hBAD0BAD0;
    cycle(1'b0, none);
    for (int i = 0; i < 3; i++) begin
      req_key = 8'h34;
      wr_en = (i == 0); wr_idx = 1; wr_key = 8'h12; wr_data = 32'h99999999;
      cycle(1'b0, none);
    end
    wr_en = 0; rsp_ready = 1; req_key = 8'h12;
    cycle(1'b0, none);
    idle_inputs();
    cycle(1'b0, none);

    // Random scoreboard run
    accepted = 0;
    for (int c = 0; c < 3000 && accepted < 100; c++) begin
      req_valid = ($urandom % 4) != 0;
      req_key = ($urandom % 5 == 4) ? 8'($urandom) : keys[$urandom % 4];
      default_data = $urandom;
      rsp_ready = ($urandom % 3) != 0;
      wr_en = ($urandom % 6) == 0;
      wr_idx = 2'($urandom);
      wr_key = keys[$urandom % 4];
      wr_data = $urandom;
      inv_en = ($urandom % 40) == 0;
      if (req_valid && (sb.size() == 0 || rsp_ready)) accepted++;
      cycle(1'b0, none);
    end
    chk("random_accepted", accepted, 100);
    idle_inputs();
    cycle(1'b0, none);
    chk("random_sb_empty", sb.size(), 0);
    chk("random_drained", rsp_valid, 0);

    // Reset mid-operation, with a concurrent write that must be ignored
    wr_en = 1; wr_idx = 3; wr_key = 8'h34; wr_data = 32'h3;
    cycle(1'b0, none);
    idle_inputs();
    req_valid = 1; req_key = 8'h34; rsp_ready = 0;
    cycle(1'b0, none);
    rst_n = 0; wr_en = 1; wr_idx = 0; wr_key = 8'h99; wr_data = 32'h9;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_rsp_hit", rsp_hit, 0);
    chk("midrst_rsp_idx", rsp_idx, 0);
    model_clear();
    sb.delete();
    rst_n = 1;
    idle_inputs();
    req_valid = 1; default_data = 32'h0F0F0F0F;
    req_key = 8'h34; cycle(1'b0, none);
    req_key = 8'h99; cycle(1'b0, none);
    req_key = 8'h12; cycle(1'b0, none);
    idle_inputs();
    cycle(1'b0, none);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_muxkey_pipe.md
Name: ysyx_23060025_muxkey_pipe

Overview:
- Registered, run-time-programmable successor to the combinational key mux.
- Holds NR_KEY {key, data} entries in flops, each with its own valid bit.
- Takes lookup requests on a valid/ready handshake and returns {data, hit} one cycle later through an output register that supports backpressure.
- Used for decode and CSR-style lookup tables in the NPC, where the table contents change at run time.

Parameters:
- NR_KEY, 4, number of table entries (>=2).
- KEY_LEN, 8, key width in bits.
- DATA_LEN, 32, data width in bits.
- IDX_LEN, $clog2(NR_KEY), entry index width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- wr_en  in  1  write one table entry this cycle.
- wr_idx  in  IDX_LEN  index of the entry to write.
- wr_key  in  KEY_LEN  key stored into entry wr_idx.
- wr_data  in  DATA_LEN  data stored into entry wr_idx.
- inv_en  in  1  invalidate every entry (clear all valid bits).
- default_data  in  DATA_LEN  value returned when a lookup misses; sampled at acceptance.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  block can accept a lookup this cycle.
- req_key  in  KEY_LEN  key to look up.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_LEN  matched data, or default_data on a miss.
- rsp_hit  out  1  1 = a valid entry matched.
- rsp_idx  out  IDX_LEN  index of the matching entry; 0 on a miss.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All entry valid bits cleared; key and data storage are don't-care.
  - rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_idx=0.
  - req_ready is 1 from the first cycle after reset.
  - Reset overrides any concurrent write, invalidate or handshake.
- Table write:
  - When wr_en=1 and inv_en=0, entry wr_idx gets {wr_key, wr_data} and its valid bit is set, at the clock edge.
  - wr_idx >= NR_KEY (non-power-of-two NR_KEY) is ignored; nothing changes.
- Invalidate:
  - inv_en=1 clears all valid bits.
  - inv_en takes priority over wr_en in the same cycle; the write is dropped.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (single output stage, no bubble under continuous flow).
  - A request is accepted when req_valid && req_ready.
- Lookup on acceptance:
  - Uses the table state before the current edge. A write or invalidate in the same cycle is not visible to this lookup; it is visible to the next one.
  - Match means entry valid && stored key == req_key.
  - If several entries match, the lowest index wins.
  - Hit: rsp_data = stored data, rsp_hit=1, rsp_idx = matching index.
  - Miss: rsp_data = default_data, rsp_hit=0, rsp_idx=0.
  - Latency: the result is registered and rsp_valid=1 in the cycle after acceptance.
- Response holding:
  - While rsp_valid && !rsp_ready, rsp_data, rsp_hit and rsp_idx hold stable. req_ready=0 in that state.
  - Table writes during a stall do not alter the held response.
- Response update:
  - rsp_valid falls when rsp_ready=1 and no new request is accepted that cycle.
  - Accept and drain in the same cycle: the register loads the new result and rsp_valid stays 1.
- No combinational path from req_key to rsp_*. req_ready depends only on rsp_valid and rsp_ready.
- Equality compare is full KEY_LEN width; no masking.

Test Plan:
- Reset then lookup: after reset, lookup key 0x00 with default_data=0xDEADBEEF -> next cycle rsp_valid=1, rsp_hit=0, rsp_data=0xDEADBEEF, rsp_idx=0.
- Program and hit:
  - Write idx1 {0x12, 0x11112222} and idx3 {0x34, 0xAAAA5555}.
  - Lookups of 0x34 then 0x12 back-to-back with rsp_ready=1 -> responses 0xAAAA5555/idx3, then 0x11112222/idx1, on consecutive cycles, hit=1.
- Priority and same-cycle write:
  - Write idx0 and idx2 both with key 0x7F (data 0xA0, 0xA2) -> lookup 0x7F returns 0xA0, idx0.
  - Rewrite idx0 to key 0x00 in the same cycle as a lookup of 0x7F -> that lookup returns 0xA0; the next lookup of 0x7F returns 0xA2, idx2.
- Backpressure:
  - Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and rsp_* stable for all 3 cycles.
  - Raise rsp_ready -> the pending request is accepted that cycle and its result appears the next cycle. No request is lost or duplicated (scoreboard over 100 random requests).
- Invalidate vs write: assert inv_en and wr_en (idx2, key 0x55) in the same cycle -> a subsequent lookup of 0x55 misses; earlier-programmed keys also miss.
- Reset mid-operation: rst_n=0 while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, all entries miss; req_ready=1 after reset is released.
